// File: rtl/vector_op_sequencer_if.sv
// Issue-stage and memory-port signals of the vector op sequencer.
// The sequencer uses the slave modport; the issue stage / memory side uses master.
interface vector_op_sequencer_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic              op_valid;
    logic              op_ready;
    logic [4:0]        op_code;
    logic [3:0]        op_vd;
    logic [3:0]        op_va;
    logic [3:0]        op_vb;
    logic [ADDR_W-1:0] op_base;
    logic [1:0]        alu_sel;
    logic              lane_en;
    logic [LW-1:0]     lane_idx;
    logic [3:0]        vreg_raddr_a;
    logic [3:0]        vreg_raddr_b;
    logic [3:0]        vreg_waddr;
    logic              vreg_we;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  op_valid, op_code, op_vd, op_va, op_vb, op_base, mem_ack,
        output op_ready, alu_sel, lane_en, lane_idx, vreg_raddr_a, vreg_raddr_b,
               vreg_waddr, vreg_we, mem_req, mem_we, mem_addr, busy, done, err
    );

    modport master (
        output op_valid, op_code, op_vd, op_va, op_vb, op_base, mem_ack,
        input  op_ready, alu_sel, lane_en, lane_idx, vreg_raddr_a, vreg_raddr_b,
               vreg_waddr, vreg_we, mem_req, mem_we, mem_addr, busy, done, err
    );
endinterface

// File: rtl/vector_op_sequencer.sv
// Multi-cycle sequencer: steps one vector instruction lane by lane through the
// shared lane ALU or the single-word memory port, holding off issue until done.
module vector_op_sequencer #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADDR_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    vector_op_sequencer_if.slave  bus
);
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LastLane = LW'(LANES - 1);

    typedef enum logic [2:0] {StIdle, StAlu, StMem, StDone, StErr} state_e;

    state_e            state;
    logic [LW-1:0]     cnt;
    logic              is_store;
    logic [1:0]        alu_sel_q;
    logic [3:0]        ra_q;
    logic [3:0]        rb_q;
    logic [3:0]        wa_q;
    logic [ADDR_W-1:0] base_q;

    // Sequencer FSM: instruction latch, lane counter and state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            is_store  <= 1'b0;
            alu_sel_q <= 2'b00;
            ra_q      <= '0;
            rb_q      <= '0;
            wa_q      <= '0;
            base_q    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.op_valid) begin
                        cnt    <= '0;
                        ra_q   <= bus.op_va;
                        rb_q   <= bus.op_vb;
                        wa_q   <= bus.op_vd;
                        base_q <= bus.op_base;
                        case (bus.op_code)
                            5'b10000: begin state <= StAlu; alu_sel_q <= 2'b00; end
                            5'b10001: begin state <= StAlu; alu_sel_q <= 2'b01; end
                            5'b10010: begin state <= StAlu; alu_sel_q <= 2'b10; end
                            5'b10100: begin
                                state     <= StMem;
                                alu_sel_q <= 2'b11;
                                is_store  <= 1'b0;
                            end
                            5'b10101: begin
                                state     <= StMem;
                                alu_sel_q <= 2'b11;
                                is_store  <= 1'b1;
                            end
                            default:  state <= StErr;
                        endcase
                    end
                end
                StAlu: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LastLane) state <= StDone;
                end
                StMem: begin
                    // Lane and address stay put until the memory acknowledges.
                    if (bus.mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LastLane) state <= StDone;
                    end
                end
                StDone:  state <= StIdle;
                StErr:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Strobes decoded from state; load write-enable follows ack combinationally.
    always_comb begin
        bus.op_ready     = (state == StIdle);
        bus.busy         = (state != StIdle);
        bus.done         = (state == StDone);
        bus.err          = (state == StErr);
        bus.lane_en      = (state == StAlu);
        bus.mem_req      = (state == StMem);
        bus.mem_we       = (state == StMem) && is_store;
        bus.vreg_we      = (state == StAlu) || ((state == StMem) && !is_store && bus.mem_ack);
        bus.lane_idx     = cnt;
        bus.mem_addr     = base_q + ADDR_W'(cnt);
        bus.alu_sel      = alu_sel_q;
        bus.vreg_raddr_a = ra_q;
        bus.vreg_raddr_b = rb_q;
        bus.vreg_waddr   = wa_q;
    end
endmodule

// File: tb/tb_vector_op_sequencer.sv
// Randomized bench for vector_op_sequencer: each instruction's expected cycle-by-cycle
// behaviour is derived from the opcode table, lane count and ack wait pattern.
module tb_vector_op_sequencer;
    localparam int unsigned LANES  = 4;
    localparam int unsigned ADDR_W = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   waits[LANES];

    vector_op_sequencer_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus ();

    vector_op_sequencer #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // 0 = illegal, 1 = arithmetic, 2 = memory
    function automatic int kind_of(input logic [4:0] c);
        case (c)
            5'b10000, 5'b10001, 5'b10010: return 1;
            5'b10100, 5'b10101:           return 2;
            default:                      return 0;
        endcase
    endfunction

    function automatic logic [1:0] sel_of(input logic [4:0] c);
        case (c)
            5'b10000: return 2'b00;
            5'b10001: return 2'b01;
            5'b10010: return 2'b10;
            default:  return 2'b11;
        endcase
    endfunction

    // Issue one instruction (caller sits at posedge+1 in an idle cycle) and check it
    // to completion, ending at posedge+1 of the next idle cycle.
    task automatic run_op(input logic [4:0] code, input logic [3:0] vd, input logic [3:0] va,
                          input logic [3:0] vb, input logic [ADDR_W-1:0] base);
        int kind;
        bit store;
        int addr;
        kind  = kind_of(code);
        store = (code == 5'b10101);
        check_eq("ready_before_issue", bus.op_ready, 1);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_vd    = vd;
        bus.op_va    = va;
        bus.op_vb    = vb;
        bus.op_base  = base;
        next_cycle();  // T0 edge passed
        bus.op_valid = 1'b0;
        bus.op_code  = 5'($urandom);
        bus.op_vd    = 4'($urandom);
        bus.op_base  = ADDR_W'($urandom);
        if (kind == 0) begin
            bus.mem_ack = 1'($urandom);
            #1;
            check_eq("err_pulse", bus.err, 1);
            check_eq("err_no_done", bus.done, 0);
            check_eq("err_no_req", bus.mem_req, 0);
            check_eq("err_no_we", bus.vreg_we, 0);
            check_eq("err_not_ready", bus.op_ready, 0);
            next_cycle();
        end else if (kind == 1) begin
            for (int k = 0; k < LANES; k++) begin
                bus.mem_ack = 1'($urandom);  // must be ignored without a request
                #1;
                check_eq("alu_lane_en", bus.lane_en, 1);
                check_eq("alu_vreg_we", bus.vreg_we, 1);
                check_eq("alu_lane_idx", 32'(bus.lane_idx), k);
                check_eq("alu_sel", bus.alu_sel, sel_of(code));
                check_eq("alu_waddr", bus.vreg_waddr, vd);
                check_eq("alu_raddr_a", bus.vreg_raddr_a, va);
                check_eq("alu_raddr_b", bus.vreg_raddr_b, vb);
                check_eq("alu_no_req", bus.mem_req, 0);
                check_eq("alu_busy", bus.busy, 1);
                check_eq("alu_no_done", bus.done, 0);
                next_cycle();
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                addr = (int'(base) + k) % (1 << ADDR_W);
                for (int w = 0; w <= waits[k]; w++) begin
                    bus.mem_ack = (w == waits[k]);
                    #1;
                    check_eq("mem_req", bus.mem_req, 1);
                    check_eq("mem_we", bus.mem_we, store);
                    check_eq("mem_addr", bus.mem_addr, addr);
                    check_eq("mem_lane_idx", 32'(bus.lane_idx), k);
                    check_eq("mem_alu_sel", bus.alu_sel, 2'b11);
                    check_eq("mem_vreg_we", bus.vreg_we, !store && (w == waits[k]));
                    check_eq("mem_lane_en", bus.lane_en, 0);
                    check_eq("mem_no_done", bus.done, 0);
                    if (!store) check_eq("mem_waddr", bus.vreg_waddr, vd);
                    else        check_eq("mem_raddr_a", bus.vreg_raddr_a, va);
                    next_cycle();
                end
            end
        end
        if (kind != 0) begin
            bus.mem_ack = 1'($urandom);
            #1;
            check_eq("done_pulse", bus.done, 1);
            check_eq("done_no_err", bus.err, 0);
            check_eq("done_no_req", bus.mem_req, 0);
            check_eq("done_no_we", bus.vreg_we, 0);
            check_eq("done_not_ready", bus.op_ready, 0);
            next_cycle();
        end
        bus.mem_ack = 1'b0;
        check_eq("ready_after", bus.op_ready, 1);
        check_eq("idle_no_done", bus.done, 0);
        check_eq("idle_no_err", bus.err, 0);
        check_eq("idle_not_busy", bus.busy, 0);
    endtask

    initial begin
        logic [4:0] code;
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_code  = '0;
        bus.op_vd    = '0;
        bus.op_va    = '0;
        bus.op_vb    = '0;
        bus.op_base  = '0;
        bus.mem_ack  = 1'b0;
        foreach (waits[i]) waits[i] = 0;
        #1;
        check_eq("rst_ready", bus.op_ready, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_req", bus.mem_req, 0);
        check_eq("rst_alu_sel", bus.alu_sel, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check_eq("post_rst_ready", bus.op_ready, 1);
        check_eq("post_rst_strobes", {bus.lane_en, bus.vreg_we, bus.mem_req, bus.mem_we,
                                      bus.done, bus.err}, 0);

        // Directed arithmetic ops.
        run_op(5'b10000, 4'd3, 4'd1, 4'd2, 16'h0000);
        run_op(5'b10001, 4'd3, 4'd1, 4'd2, 16'h0000);
        run_op(5'b10010, 4'd3, 4'd1, 4'd2, 16'h0000);
        // VLDR with lane 1 acked two cycles late.
        waits = '{0, 2, 0, 0};
        run_op(5'b10100, 4'd5, 4'd0, 4'd0, 16'h0100);
        // VSTR wrapping the address space, zero-wait.
        waits = '{0, 0, 0, 0};
        run_op(5'b10101, 4'd0, 4'd7, 4'd0, 16'hFFFE);
        // Illegal opcodes.
        run_op(5'b10011, 4'd1, 4'd1, 4'd1, 16'h0000);
        run_op(5'b00000, 4'd1, 4'd1, 4'd1, 16'h0000);

        // Reset during VLDR lane 2 with the ack pending.
        bus.op_valid = 1'b1;
        bus.op_code  = 5'b10100;
        bus.op_vd    = 4'd9;
        bus.op_base  = 16'h0200;
        next_cycle();
        bus.op_valid = 1'b0;
        bus.mem_ack  = 1'b1;
        next_cycle();
        next_cycle();
        bus.mem_ack  = 1'b0;
        #1;
        check_eq("pre_rst_lane", 32'(bus.lane_idx), 2);
        check_eq("pre_rst_req", bus.mem_req, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_req", bus.mem_req, 0);
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_ready", bus.op_ready, 1);
        check_eq("mid_rst_lane", 32'(bus.lane_idx), 0);
        check_eq("mid_rst_addr", bus.mem_addr, 0);
        bus.mem_ack = 1'b1;
        next_cycle();
        check_eq("rst_held_req", bus.mem_req, 0);
        rst         = 1'b0;
        bus.mem_ack = 1'b0;
        next_cycle();
        check_eq("rst_rel_we", bus.vreg_we, 0);
        run_op(5'b10000, 4'd4, 4'd5, 4'd6, 16'h0000);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: code = 5'b10000;
                1: code = 5'b10001;
                2: code = 5'b10010;
                3: code = 5'b10100;
                4: code = 5'b10101;
                default: code = 5'($urandom);
            endcase
            foreach (waits[i]) waits[i] = $urandom_range(0, 2);
            run_op(code, 4'($urandom), 4'($urandom), 4'($urandom), ADDR_W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so a stuck DUT can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
